// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, the halt encoding and the queue entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // beq x0,x0,0 : a branch to itself, used by programs as "stop here"
  localparam logic [31:0] HALT_INSTR = 32'h0000_0063;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc,instr} entries with synchronous flush; head is presented combinationally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  fetch_entry_t        r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;

  // Pointers and occupancy only; payload storage carries no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When full, a simultaneous push overwrites the slot being popped this same edge.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= wr_entry;
  end

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign rd_entry = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC register, fetch FSM and next-PC mux feeding a small fetch queue towards decode.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds misalign_err and traps misaligned redirects.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] HALT_INSTR = fetch_pkg::HALT_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic        halted
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         w_redir, w_redir_ok;
  logic         w_push, w_pop, w_flush;
  logic         w_full, w_empty;
  fetch_entry_t w_wr_entry, w_rd_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;
  logic w_misalign;

  // Once trapped, redirects are ignored until reset so the faulting state is preserved.
  assign w_redir    = redirect_valid && !r_misalign;
  assign w_misalign = w_redir && (redirect_target[1:0] != 2'b00);
  assign w_redir_ok = w_redir && !w_misalign;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_misalign <= 1'b0;
    else if (w_misalign) r_misalign <= 1'b1;
  end

  assign misalign_err = r_misalign;
`else
  assign w_redir    = redirect_valid;
  assign w_redir_ok = redirect_valid;
`endif

  assign w_flush = w_redir;
  assign w_pop   = !w_empty && id_ready && !w_flush;
  assign w_push  = (r_state == FETCH) && !redirect_valid &&
                   (!w_full || (!w_empty && id_ready));

  assign w_wr_entry = '{pc: r_pc, instr: imem_data};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      IDLE:  w_state_nxt = FETCH;
      FETCH: begin
        if (w_push) begin
          if (imem_data == HALT_INSTR) w_state_nxt = HALTED;
          else                         w_pc_nxt    = r_pc + 32'd4;
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase
    if (w_redir_ok) begin
      w_state_nxt = FETCH;
      w_pc_nxt    = {redirect_target[31:2], 2'b00};
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    if (w_misalign) w_state_nxt = HALTED;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (reset_n),
    .push     (w_push),
    .pop      (w_pop),
    .flush    (w_flush),
    .wr_entry (w_wr_entry),
    .rd_entry (w_rd_entry),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign imem_addr = r_pc;
  assign id_valid  = !w_empty;
  assign id_pc     = w_rd_entry.pc;
  assign id_instr  = w_rd_entry.instr;
  assign halted    = (r_state == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational instruction memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        halted;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  logic [31:0] halt_addr;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  // Every word ends in 12'h013, so only halt_addr can ever return the halt encoding.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return {a[19:0], 12'h013};
  endfunction

  assign imem_data = (imem_addr == halt_addr) ? 32'h0000_0063 : instr_at(imem_addr);

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_pc           (id_pc),
    .id_instr        (id_instr),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_err    (misalign_err),
`endif
    .halted          (halted)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    tick();
    redirect_valid  = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    id_ready        = 1'b1;
    halt_addr       = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Test 1: streaming from reset
    reset_n = 1'b1;
    tick();
    chk("t1_idle_no_valid", {31'b0, id_valid}, 32'h0);
    chk("t1_idle_addr", imem_addr, 32'h0);
    tick();
    chk("t1_first_valid", {31'b0, id_valid}, 32'h1);
    chk("t1_first_pc", id_pc, 32'h0);
    chk("t1_first_instr", id_instr, 32'h0000_0013);
    exp_pc = 32'h4;
    repeat (4) begin
      tick();
      chk("t1_stream_pc", id_pc, exp_pc);
      chk("t1_stream_instr", id_instr, instr_at(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end

    // Test 2: backpressure fills the queue; pc freezes two words past the head
    id_ready = 1'b0;
    repeat (5) tick();
    chk("t2_hold_valid", {31'b0, id_valid}, 32'h1);
    chk("t2_hold_pc", id_pc, 32'h10);
    chk("t2_pc_frozen", imem_addr, 32'h18);
    id_ready = 1'b1;
    exp_pc = 32'h14;
    repeat (4) begin
      tick();
      chk("t2_resume_pc", id_pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end

    // Test 3: redirect with a full queue and a live handshake
    redirect(32'h64);
    chk("t3_flushed", {31'b0, id_valid}, 32'h0);
    chk("t3_addr", imem_addr, 32'h64);
    tick();
    chk("t3_valid", {31'b0, id_valid}, 32'h1);
    chk("t3_pc", id_pc, 32'h64);
    chk("t3_instr", id_instr, instr_at(32'h64));

    // Test 4: halt word at 0x34
    halt_addr = 32'h34;
    redirect(32'h2C);
    tick();
    chk("t4_pc_2c", id_pc, 32'h2C);
    tick();
    chk("t4_pc_30", id_pc, 32'h30);
    tick();
    chk("t4_halt_pc", id_pc, 32'h34);
    chk("t4_halt_instr", id_instr, 32'h0000_0063);
    chk("t4_halted", {31'b0, halted}, 32'h1);
    chk("t4_addr_hold", imem_addr, 32'h34);
    tick();
    tick();
    chk("t4_no_more_push", {31'b0, id_valid}, 32'h0);
    chk("t4_addr_still", imem_addr, 32'h34);
    chk("t4_still_halted", {31'b0, halted}, 32'h1);
    redirect(32'h0);
    chk("t4_unhalt", {31'b0, halted}, 32'h0);
    chk("t4_unhalt_addr", imem_addr, 32'h0);
    halt_addr = 32'hFFFF_FFFF;

    // Test 5: address wrap, then asynchronous reset mid-stream
    redirect(32'hFFFF_FFF8);
    chk("t5_addr_fff8", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("t5_pc_fff8", id_pc, 32'hFFFF_FFF8);
    tick();
    chk("t5_pc_fffc", id_pc, 32'hFFFF_FFFC);
    chk("t5_wrap_addr", imem_addr, 32'h0);
    tick();
    chk("t5_pc_wrap", id_pc, 32'h0);
    chk("t5_instr_wrap", id_instr, 32'h0000_0013);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_valid", {31'b0, id_valid}, 32'h0);
    chk("t5_async_pc", id_pc, 32'h0);
    chk("t5_async_addr", imem_addr, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t5_restart_idle", {31'b0, id_valid}, 32'h0);
    tick();
    chk("t5_restart_valid", {31'b0, id_valid}, 32'h1);
    chk("t5_restart_pc", id_pc, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Test 6: misaligned redirect traps; later redirects are ignored
    redirect(32'h66);
    chk("t6_err", {31'b0, misalign_err}, 32'h1);
    chk("t6_halted", {31'b0, halted}, 32'h1);
    chk("t6_flushed", {31'b0, id_valid}, 32'h0);
    chk("t6_pc_kept", imem_addr, 32'h4);
    redirect(32'h0);
    chk("t6_ignored_halted", {31'b0, halted}, 32'h1);
    chk("t6_err_sticky", {31'b0, misalign_err}, 32'h1);
    chk("t6_ignored_addr", imem_addr, 32'h4);
`else
    // Low target bits are dropped when the check is not built in
    redirect(32'h66);
    chk("t6_masked_addr", imem_addr, 32'h64);
    chk("t6_not_halted", {31'b0, halted}, 32'h0);
    tick();
    chk("t6_masked_pc", id_pc, 32'h64);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
